// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requesters onto one shared memory port (load/store wins ties).
// Optional wait-state timeout abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [15:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic [31:0] ls_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      LS_WAIT = 2'd2
   } state_t;

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 1..255");
   end

   state_t      state_r, state_s;
   logic        mem_req_r, mem_req_s;
   logic        mem_we_r, mem_we_s;
   logic [15:0] mem_addr_r, mem_addr_s;
   logic [31:0] mem_wdata_r, mem_wdata_s;
   logic        if_ack_r, if_ack_s;
   logic        ls_ack_r, ls_ack_s;
   logic [31:0] if_rdata_r, if_rdata_s;
   logic [31:0] ls_rdata_r, ls_rdata_s;
   logic        busy_r, busy_s;
   logic        if_elig_s, ls_elig_s;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  cnt_r, cnt_s;
   logic        err_r, err_s;
`endif

   // A requester whose ack is still high is holding a finished request and must not be re-granted.
   assign if_elig_s = if_req & ~if_ack_r;
   assign ls_elig_s = ls_req & ~ls_ack_r;

   // Next-state and next-output logic for the arbitration FSM.
   always_comb begin
      state_s     = state_r;
      mem_req_s   = mem_req_r;
      mem_we_s    = mem_we_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      if_ack_s    = 1'b0;
      ls_ack_s    = 1'b0;
      if_rdata_s  = if_rdata_r;
      ls_rdata_s  = ls_rdata_r;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_s       = cnt_r;
      err_s       = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (ls_elig_s) begin
               state_s     = LS_WAIT;
               mem_req_s   = 1'b1;
               mem_we_s    = ls_we;
               mem_addr_s  = ls_addr;
               mem_wdata_s = ls_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_s       = 8'd0;
`endif
            end else if (if_elig_s) begin
               state_s     = IF_WAIT;
               mem_req_s   = 1'b1;
               mem_we_s    = 1'b0;
               mem_addr_s  = if_addr;
               mem_wdata_s = 32'h0000_0000;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_s       = 8'd0;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         IF_WAIT, LS_WAIT: begin
            if (mem_ready) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
               if (state_r == IF_WAIT) begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = mem_rdata;
               end else begin
                  ls_ack_s = 1'b1;
                  // Stores complete without disturbing the last load value.
                  if (!mem_we_r) begin
                     ls_rdata_s = mem_rdata;
                  end else begin
                     ls_rdata_s = ls_rdata_r;
                  end
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_r == TIMEOUT_LIMIT) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
               err_s     = 1'b1;
               if (state_r == IF_WAIT) begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = 32'h0000_0000;
               end else begin
                  ls_ack_s   = 1'b1;
                  ls_rdata_s = 32'h0000_0000;
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
`else
            else begin
               state_s = state_r;
            end
`endif
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and registered-output update; reset abandons any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 16'h0000;
         mem_wdata_r <= 32'h0000_0000;
         if_ack_r    <= 1'b0;
         ls_ack_r    <= 1'b0;
         if_rdata_r  <= 32'h0000_0000;
         ls_rdata_r  <= 32'h0000_0000;
         busy_r      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_r       <= 8'd0;
         err_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         mem_req_r   <= mem_req_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         if_ack_r    <= if_ack_s;
         ls_ack_r    <= ls_ack_s;
         if_rdata_r  <= if_rdata_s;
         ls_rdata_r  <= ls_rdata_s;
         busy_r      <= busy_s;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_r       <= cnt_s;
         err_r       <= err_s;
`endif
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_ack    = if_ack_r;
   assign ls_ack    = ls_ack_r;
   assign if_rdata  = if_rdata_r;
   assign ls_rdata  = ls_rdata_r;
   assign busy      = busy_r;
`ifdef MEM_ARB_TIMEOUT_EN
   assign err       = err_r;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner-case sequences, and a
// randomized run against a transaction-level reference model (honours MEM_ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, ls_req, ls_we, mem_ready;
   logic [15:0] if_addr, ls_addr;
   logic [31:0] ls_wdata, mem_rdata;
   logic        if_ack, ls_ack, mem_req, mem_we, busy, err;
   logic [31:0] if_rdata, ls_rdata, mem_wdata;
   logic [15:0] mem_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .err(err)
   );

   typedef struct {
      bit          is_ls;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          ready_dly;
      logic [31:0] rdata;
      logic [31:0] exp_if_rdata;
      logic [31:0] exp_ls_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from the directed table
   task automatic run_vec(input vec_t v);
      if (v.is_ls) begin
         ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      mem_ready = 1'b0;
      tick();
      chk1("vec_mem_req_grant", mem_req, 1'b1);
      chk32("vec_mem_addr", {16'h0000, mem_addr}, {16'h0000, v.addr});
      chk1("vec_mem_we", mem_we, v.is_ls ? v.we : 1'b0);
      if (v.is_ls) chk32("vec_mem_wdata", mem_wdata, v.wdata);
      chk1("vec_busy", busy, 1'b1);
      for (int d = 0; d < v.ready_dly; d++) begin
         tick();
         chk1("vec_wait_mem_req", mem_req, 1'b1);
         chk1("vec_wait_if_ack", if_ack, 1'b0);
         chk1("vec_wait_ls_ack", ls_ack, 1'b0);
      end
      mem_ready = 1'b1; mem_rdata = v.rdata;
      tick();
      mem_ready = 1'b0; mem_rdata = $urandom();
      chk1("vec_if_ack", if_ack, !v.is_ls);
      chk1("vec_ls_ack", ls_ack, v.is_ls);
      chk1("vec_done_mem_req", mem_req, 1'b0);
      chk1("vec_done_busy", busy, 1'b0);
      chk1("vec_done_err", err, 1'b0);
      chk32("vec_if_rdata", if_rdata, v.exp_if_rdata);
      chk32("vec_ls_rdata", ls_rdata, v.exp_ls_rdata);
      tick();
      chk1("vec_no_regrant", mem_req, 1'b0);
      chk1("vec_ack_pulse_if", if_ack, 1'b0);
      chk1("vec_ack_pulse_ls", ls_ack, 1'b0);
      if_req = 1'b0; ls_req = 1'b0;
      tick();
   endtask

   // Reference model: which requester is being served and the values it should see
   int          m_srv;
   int          m_waited;
   logic [15:0] m_addr;
   logic        m_we;
   logic [31:0] m_wdata;
   logic        m_if_ack, m_ls_ack, m_err;
   logic [31:0] m_if_rdata, m_ls_rdata;

   task automatic model_step();
      logic n_if_ack, n_ls_ack, n_err;
      n_if_ack = 1'b0; n_ls_ack = 1'b0; n_err = 1'b0;
      if (rst) begin
         m_srv = 0; m_if_rdata = 32'h0; m_ls_rdata = 32'h0;
      end else if (m_srv == 0) begin
         if (ls_req && !m_ls_ack) begin
            m_srv = 2; m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata; m_waited = 0;
         end else if (if_req && !m_if_ack) begin
            m_srv = 1; m_addr = if_addr; m_we = 1'b0; m_waited = 0;
         end
      end else if (mem_ready) begin
         if (m_srv == 1) begin
            n_if_ack = 1'b1; m_if_rdata = mem_rdata;
         end else begin
            n_ls_ack = 1'b1;
            if (!m_we) m_ls_rdata = mem_rdata;
         end
         m_srv = 0;
      end else begin
         m_waited++;
`ifdef MEM_ARB_TIMEOUT_EN
         if (m_waited == TO) begin
            if (m_srv == 1) begin
               n_if_ack = 1'b1; m_if_rdata = 32'h0;
            end else begin
               n_ls_ack = 1'b1; m_ls_rdata = 32'h0;
            end
            n_err = 1'b1;
            m_srv = 0;
         end
`endif
      end
      m_if_ack = n_if_ack; m_ls_ack = n_ls_ack; m_err = n_err;
   endtask

   task automatic model_compare();
      chk1("rnd_mem_req", mem_req, m_srv != 0);
      chk1("rnd_busy", busy, m_srv != 0);
      chk1("rnd_if_ack", if_ack, m_if_ack);
      chk1("rnd_ls_ack", ls_ack, m_ls_ack);
      chk1("rnd_err", err, m_err);
      chk32("rnd_if_rdata", if_rdata, m_if_rdata);
      chk32("rnd_ls_rdata", ls_rdata, m_ls_rdata);
      if (m_srv != 0) begin
         chk32("rnd_mem_addr", {16'h0000, mem_addr}, {16'h0000, m_addr});
         chk1("rnd_mem_we", mem_we, m_we);
         if (m_srv == 2) chk32("rnd_mem_wdata", mem_wdata, m_wdata);
      end
   endtask

   initial begin
      int if_ph, ls_ph, hi;

      vecs[0] = '{1'b0, 1'b0, 16'h0004, 32'h0, 2, 32'h0050_0093, 32'h0050_0093, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 16'h0100, 32'h0, 0, 32'h1122_3344, 32'h0050_0093, 32'h1122_3344};
      vecs[2] = '{1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF, 32'h0050_0093, 32'h1122_3344};
      vecs[3] = '{1'b0, 1'b0, 16'hFFFC, 32'h0, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1122_3344};
      vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 32'h0, 2, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_0000};
      vecs[5] = '{1'b1, 1'b1, 16'h8000, 32'hFFFF_FFFF, 2, 32'h5555_AAAA, 32'hA5A5_A5A5, 32'h0000_0000};

      // Reset, with requests and mem_ready asserted to show reset dominates
      rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; mem_ready = 1'b1;
      if_addr = 16'h1234; ls_addr = 16'h5678; ls_wdata = 32'h9999_9999; mem_rdata = 32'h7777_7777;
      tick(); tick();
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_mem_addr", {16'h0000, mem_addr}, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_ls_ack", ls_ack, 1'b0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_ls_rdata", ls_rdata, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b1;
      rst = 1'b0;
      tick();
      chk1("idle_ready_ignored_req", mem_req, 1'b0);
      chk1("idle_ready_ignored_if", if_ack, 1'b0);
      chk1("idle_ready_ignored_ls", ls_ack, 1'b0);
      mem_ready = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Simultaneous requests: load/store first, fetch granted the cycle ls_ack is high
      if_req = 1'b1; if_addr = 16'h0200;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
      tick();
      chk32("sim_first_addr", {16'h0000, mem_addr}, 32'h0000_0100);
      chk1("sim_first_req", mem_req, 1'b1);
      mem_ready = 1'b1; mem_rdata = 32'h7777_8888;
      tick();
      mem_ready = 1'b0;
      chk1("sim_ls_ack", ls_ack, 1'b1);
      chk1("sim_if_ack_early", if_ack, 1'b0);
      chk1("sim_no_req_at_ls_ack", mem_req, 1'b0);
      chk32("sim_ls_rdata", ls_rdata, 32'h7777_8888);
      tick();
      chk1("sim_if_grant", mem_req, 1'b1);
      chk32("sim_if_addr", {16'h0000, mem_addr}, 32'h0000_0200);
      chk1("sim_if_we", mem_we, 1'b0);
      ls_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ready = 1'b0;
      chk1("sim_if_ack", if_ack, 1'b1);
      chk1("sim_ls_ack_pulse", ls_ack, 1'b0);
      chk32("sim_if_rdata", if_rdata, 32'h0BAD_F00D);
      tick();
      chk1("sim_end_idle", mem_req, 1'b0);
      if_req = 1'b0;
      tick();

      // Wait-state limit
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0040;
      tick();
      chk1("to_grant", mem_req, 1'b1);
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         chk1("to_wait_req", mem_req, 1'b1);
         chk1("to_wait_err", err, 1'b0);
         chk1("to_wait_ack", ls_ack, 1'b0);
      end
      tick();
      chk1("to_ls_ack", ls_ack, 1'b1);
      chk1("to_err", err, 1'b1);
      chk32("to_ls_rdata", ls_rdata, 32'h0);
      chk1("to_mem_req", mem_req, 1'b0);
      chk1("to_busy", busy, 1'b0);
      tick();
      chk1("to_err_pulse", err, 1'b0);
      chk1("to_no_regrant", mem_req, 1'b0);
`else
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (mem_req && !err && !ls_ack) hi++;
      end
      chk32("nto_held_cycles", 32'(hi), 32'd100);
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ready = 1'b0;
      chk1("nto_ls_ack", ls_ack, 1'b1);
      chk1("nto_err", err, 1'b0);
      chk32("nto_ls_rdata", ls_rdata, 32'h1234_5678);
      tick();
`endif
      ls_req = 1'b0;
      tick();

      // Reset in the second wait cycle of a fetch, with same-cycle mem_ready
      if_req = 1'b1; if_addr = 16'h0008;
      tick();
      tick();
      chk1("rmid_waiting", mem_req, 1'b1);
      rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      rst = 1'b0; mem_ready = 1'b0;
      chk1("rmid_mem_req", mem_req, 1'b0);
      chk1("rmid_busy", busy, 1'b0);
      chk1("rmid_if_ack", if_ack, 1'b0);
      chk1("rmid_err", err, 1'b0);
      chk32("rmid_if_rdata", if_rdata, 32'h0);
      tick();
      chk1("rmid_regrant", mem_req, 1'b1);
      chk32("rmid_addr", {16'h0000, mem_addr}, 32'h0000_0008);
      mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
      tick();
      mem_ready = 1'b0;
      chk1("rmid_if_ack_after", if_ack, 1'b1);
      chk32("rmid_if_rdata_after", if_rdata, 32'h0000_0013);
      tick();
      if_req = 1'b0;
      tick();

      // Randomized run against the reference model
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
      if_ph = 0; ls_ph = 0;
      m_if_ack = 1'b0; m_ls_ack = 1'b0; m_err = 1'b0; m_srv = 0; m_waited = 0;
      m_addr = 16'h0; m_we = 1'b0; m_wdata = 32'h0;
      model_step();
      tick();
      model_compare();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (if_ph == 1 && if_ack) if_ph = 2;
         else if (if_ph == 2) begin if_req = 1'b0; if_ph = 0; end
         else if (if_ph == 0 && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 16'($urandom()); if_ph = 1;
         end
         if (ls_ph == 1 && ls_ack) ls_ph = 2;
         else if (ls_ph == 2) begin ls_req = 1'b0; ls_ph = 0; end
         else if (ls_ph == 0 && $urandom_range(0, 2) == 0) begin
            ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_addr = 16'($urandom());
            ls_wdata = $urandom(); ls_ph = 1;
         end
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom();
         rst = ($urandom_range(0, 149) == 0);
         model_step();
         tick();
         model_compare();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
